// File: rtl/frame_serializer_pkg.sv
// Shared definitions for the frame serializer: FSM state codes and default
// frame geometry, which must stay in step with the detector's window length.
package frame_serializer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // 20 data bits plus 1 gap cycle lines up with the detector's 21-cycle window.
    localparam int DEF_FRAME_BITS = 20;
    localparam int DEF_GAP_CYCLES = 1;
    localparam int DEF_CNT_W      = 8;

endpackage

// File: rtl/frame_serializer_skid_buf.sv
// One-entry frame holding register with a full flag, used by frame_serializer
// to queue the next frame while the current one is still being shifted out.
module frame_skid_buf #(
    parameter int W = 20
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr,
    input  logic [W-1:0] wdata,
    input  logic         rd,
    output logic [W-1:0] rdata,
    output logic         full
);

    logic [W-1:0] data;

    // A write on the same edge as a read leaves the new frame held and the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data <= '0;
            full <= 1'b0;
        end else begin
            if (wr)
                data <= wdata;
            if (wr)
                full <= 1'b1;
            else if (rd)
                full <= 1'b0;
        end
    end

    assign rdata = data;

endmodule

// File: rtl/frame_serializer.sv
// Parallel-to-serial frame feeder for the pattern detector: LSB-first bits,
// then a gap cycle per frame. Define FRAME_SER_SKID_BUF_EN for back-to-back frames.
module frame_serializer
    import frame_serializer_pkg::*;
#(
    parameter int FRAME_BITS = DEF_FRAME_BITS,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FRAME_BITS-1:0] in_frame,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  serial_out,
    output logic                  bit_valid,
    output logic                  frame_start,
    output logic                  frame_end,
    output logic [CNT_W-1:0]      frames_sent
);

    localparam int BW = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_BITS - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    state_t                state, state_nx;
    logic [FRAME_BITS-1:0] shreg, shreg_nx;
    logic [BW-1:0]         bit_cnt, bit_cnt_nx;
    logic [GW-1:0]         gap_cnt, gap_cnt_nx;
    logic [CNT_W-1:0]      sent_cnt, sent_cnt_nx;
    logic                  transfer;
    logic                  gap_exit;
    logic                  buf_full;
    logic [FRAME_BITS-1:0] buf_data;

    assign transfer = in_valid && in_ready;
    assign gap_exit = (state == ST_GAP) && (gap_cnt == GAP_LAST);

`ifdef FRAME_SER_SKID_BUF_EN
    logic buf_wr;
    logic buf_rd;

    // Only frames that cannot go straight into the shifter are parked in the buffer.
    assign buf_wr   = transfer && (state != ST_IDLE) && !(gap_exit && !buf_full);
    assign buf_rd   = buf_full && ((state == ST_IDLE) || gap_exit);
    assign in_ready = !buf_full;

    frame_skid_buf #(
        .W (FRAME_BITS)
    ) u_skid (
        .clk   (clk),
        .rst   (rst),
        .wr    (buf_wr),
        .wdata (in_frame),
        .rd    (buf_rd),
        .rdata (buf_data),
        .full  (buf_full)
    );
`else
    assign buf_full = 1'b0;
    assign buf_data = '0;
    assign in_ready = (state == ST_IDLE);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            gap_cnt  <= '0;
            sent_cnt <= '0;
        end else begin
            state    <= state_nx;
            shreg    <= shreg_nx;
            bit_cnt  <= bit_cnt_nx;
            gap_cnt  <= gap_cnt_nx;
            sent_cnt <= sent_cnt_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        shreg_nx    = shreg;
        bit_cnt_nx  = bit_cnt;
        gap_cnt_nx  = gap_cnt;
        sent_cnt_nx = sent_cnt;
        case (state)
            ST_IDLE: begin
                if (buf_full) begin
                    shreg_nx   = buf_data;
                    bit_cnt_nx = '0;
                    state_nx   = ST_SHIFT;
                end else if (transfer) begin
                    shreg_nx   = in_frame;
                    bit_cnt_nx = '0;
                    state_nx   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shreg_nx   = shreg >> 1;
                bit_cnt_nx = bit_cnt + BW'(1);
                if (bit_cnt == BIT_LAST) begin
                    gap_cnt_nx = '0;
                    state_nx   = ST_GAP;
                end
            end
            ST_GAP: begin
                gap_cnt_nx = gap_cnt + GW'(1);
                if (gap_cnt == GAP_LAST) begin
                    sent_cnt_nx = sent_cnt + CNT_W'(1);
                    bit_cnt_nx  = '0;
                    // A queued frame wins; a frame arriving on this very edge goes straight in.
                    if (buf_full) begin
                        shreg_nx = buf_data;
                        state_nx = ST_SHIFT;
                    end else if (transfer) begin
                        shreg_nx = in_frame;
                        state_nx = ST_SHIFT;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign serial_out  = (state == ST_SHIFT) && shreg[0];
    assign bit_valid   = (state == ST_SHIFT);
    assign frame_start = (state == ST_SHIFT) && (bit_cnt == '0);
    assign frame_end   = gap_exit;
    assign frames_sent = sent_cnt;

endmodule

// File: tb/tb_frame_serializer.sv
// Directed bench for frame_serializer with hand-computed serial streams,
// handshake timing, a 2-bit wrapping frame counter and a 1111 detector model.
module tb_frame_serializer;

    localparam int FB    = 20;
    localparam int CNT_W = 2;

    logic          clk;
    logic          rst;
    logic [FB-1:0] in_frame;
    logic          in_valid;
    logic          in_ready;
    logic          serial_out;
    logic          bit_valid;
    logic          frame_start;
    logic          frame_end;
    logic [CNT_W-1:0] frames_sent;

    int vectors     = 0;
    int miscompares = 0;
    int expSent     = 0;
    int detN        = 0;

    frame_serializer #(
        .FRAME_BITS (FB),
        .GAP_CYCLES (1),
        .CNT_W      (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_frame    (in_frame),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .serial_out  (serial_out),
        .bit_valid   (bit_valid),
        .frame_start (frame_start),
        .frame_end   (frame_end),
        .frames_sent (frames_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offer a frame and return at the negedge of the cycle carrying its bit 0.
    task automatic applyStimulus(input logic [FB-1:0] f);
        bit ok = 0;
        @(negedge clk);
        in_frame = f;
        in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (in_ready) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) checkOutput("ready_timeout", 0, 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Walk one frame from bit 0 through its gap; return at the cycle after the gap.
    task automatic checkFrame(input string tag, input logic [FB-1:0] f, input bit chkReady);
        int run = 0;
        detN = 0;
        for (int i = 0; i < FB; i++) begin
            checkOutput({tag, "_bit"}, {31'd0, serial_out}, {31'd0, f[i]});
            checkOutput({tag, "_valid"}, {31'd0, bit_valid}, 1);
            checkOutput({tag, "_start"}, {31'd0, frame_start}, (i == 0) ? 1 : 0);
            if (chkReady) checkOutput({tag, "_busy"}, {31'd0, in_ready}, 0);
            if (bit_valid && serial_out) begin
                run++;
                if (run == 4) begin
                    detN++;
                    run = 0;
                end
            end else begin
                run = 0;
            end
            @(negedge clk);
        end
        checkOutput({tag, "_gapvalid"}, {31'd0, bit_valid}, 0);
        checkOutput({tag, "_gapbit"}, {31'd0, serial_out}, 0);
        checkOutput({tag, "_fend"}, {31'd0, frame_end}, 1);
        if (chkReady) checkOutput({tag, "_gapbusy"}, {31'd0, in_ready}, 0);
        expSent++;
        @(negedge clk);
        checkOutput({tag, "_sent"}, {30'd0, frames_sent}, expSent % 4);
        checkOutput({tag, "_fendlow"}, {31'd0, frame_end}, 0);
    endtask

    initial begin
        logic [FB-1:0] fa;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_frame = '0;

        // Reset values, then a reset asserted in the middle of a frame
        @(negedge clk);
        checkOutput("rst_ready", {31'd0, in_ready}, 1);
        checkOutput("rst_valid", {31'd0, bit_valid}, 0);
        checkOutput("rst_serial", {31'd0, serial_out}, 0);
        checkOutput("rst_sent", {30'd0, frames_sent}, 0);
        rst = 1'b0;
        fa = 20'hA5A5A;
        applyStimulus(fa);
        repeat (4) @(negedge clk);
        checkOutput("t1_midshift", {31'd0, bit_valid}, 1);
        checkOutput("t1_bit4", {31'd0, serial_out}, {31'd0, fa[4]});
        #2 rst = 1'b1;
        #1;
        checkOutput("t1_async_valid", {31'd0, bit_valid}, 0);
        checkOutput("t1_async_serial", {31'd0, serial_out}, 0);
        checkOutput("t1_async_start", {31'd0, frame_start}, 0);
        checkOutput("t1_async_ready", {31'd0, in_ready}, 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("t1_post_ready", {31'd0, in_ready}, 1);
        checkOutput("t1_post_sent", {30'd0, frames_sent}, 0);
        checkOutput("t1_post_fend", {31'd0, frame_end}, 0);

        // Single frame: 1,1,1,1 then zeros, gap, frame_end, count 1
        applyStimulus(20'h0000F);
        checkFrame("t2", 20'h0000F, 1'b0);
        checkOutput("t2_idle_ready", {31'd0, in_ready}, 1);

`ifdef FRAME_SER_SKID_BUF_EN
        // Back-to-back frames through the buffer
        fa = 20'h12345;
        applyStimulus(fa);
        in_frame = 20'hFEDCB;
        in_valid = 1'b1;
        checkOutput("t4_ready0", {31'd0, in_ready}, 1);
        for (int c = 0; c < 21; c++) begin
            if (c < FB) begin
                checkOutput("t4_bit", {31'd0, serial_out}, {31'd0, fa[c]});
                checkOutput("t4_start", {31'd0, frame_start}, (c == 0) ? 1 : 0);
            end else begin
                checkOutput("t4_fend", {31'd0, frame_end}, 1);
            end
            if (c > 0) checkOutput("t4_full", {31'd0, in_ready}, 0);
            @(negedge clk);
            in_valid = 1'b0;
        end
        expSent++;
        checkOutput("t4_drained", {31'd0, in_ready}, 1);
        checkFrame("t4b", 20'hFEDCB, 1'b0);
`else
        // Backpressure: second frame waits for IDLE, bit 0 at cycle 23
        applyStimulus(20'h0000F);
        in_frame = 20'hFFFFF;
        in_valid = 1'b1;
        checkFrame("t3a", 20'h0000F, 1'b1);
        checkOutput("t3_idle_ready", {31'd0, in_ready}, 1);
        checkOutput("t3_idle_valid", {31'd0, bit_valid}, 0);
        @(negedge clk);
        in_valid = 1'b0;
        checkFrame("t3b", 20'hFFFFF, 1'b1);
`endif

        // Counter wrap on the 2-bit frame counter
        applyStimulus(20'h00001);
        checkFrame("t5a", 20'h00001, 1'b0);
        applyStimulus(20'h80000);
        checkFrame("t5b", 20'h80000, 1'b0);

        // Non-overlapping 1111 detector sees two matches in 0x000FF
        applyStimulus(20'h000FF);
        checkFrame("t6", 20'h000FF, 1'b0);
        checkOutput("t6_detect_n", detN, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
